// File: rtl/imem_fetch_arb_pkg.sv
// Shared definitions for the instruction-memory fetch arbiter: default memory
// size, FSM state encoding, prefetch queue entry layout and PC legality check.
package imem_pkg;

    localparam int MEM_BYTES_DEF = 128;

    // state | meaning
    // S_FETCH | sequential fetch owns the memory port
    // S_LOAD  | loader held the port on the last cycle
    // S_FAULT | fetch halted on an illegal PC, queue drains, loader still served
    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    localparam int QENT_W = 64;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } qent_t;

    // A fetch PC is legal when word aligned and the whole word lies inside memory.
    function automatic logic pc_legal(input logic [31:0] pc, input logic [31:0] pc_max);
        return (pc[1:0] == 2'b00) && (pc <= pc_max);
    endfunction

endpackage

// File: rtl/imem_fetch_arb_if.sv
// Bundle of the memory, decode and loader signals around the fetch arbiter.
interface imem_fetch_arb_if;

    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ld_req;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [7:0]  ld_wdata;
    logic        ld_gnt;
    logic [31:0] ld_rdata;
    logic        fault;
    logic [31:0] fault_pc;

    modport slave (
        output mem_addr, mem_wdata, mem_we, instr_valid, instr, instr_pc,
               ld_gnt, ld_rdata, fault, fault_pc,
        input  mem_rdata, instr_ready, redirect, redirect_pc,
               ld_req, ld_we, ld_addr, ld_wdata
    );

    modport master (
        input  mem_addr, mem_wdata, mem_we, instr_valid, instr, instr_pc,
               ld_gnt, ld_rdata, fault, fault_pc,
        output mem_rdata, instr_ready, redirect, redirect_pc,
               ld_req, ld_we, ld_addr, ld_wdata
    );

endinterface

// File: rtl/imem_fetch_arb_fetch_q2.sv
// Two-entry prefetch FIFO holding {pc, instr} pairs. Flush beats push/pop.
// tail_pc exposes the second entry's PC so a resync can skip a head popped
// in the same cycle.
module fetch_q2 import imem_pkg::*; (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  qent_t       din,
    output logic [1:0]  count,
    output qent_t       head,
    output logic [31:0] tail_pc
);

    qent_t e0;
    qent_t e1;

    // Entry storage and occupancy; e0 is always the head.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e0    <= '0;
            e1    <= '0;
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        e0    <= din;
                        count <= 2'd1;
                    end else if (count == 2'd1) begin
                        e1    <= din;
                        count <= 2'd2;
                    end
                end
                2'b01: begin
                    if (count != 2'd0) begin
                        e0    <= e1;
                        count <= count - 2'd1;
                    end
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        e0 <= din;
                    end else if (count == 2'd2) begin
                        e0 <= e1;
                        e1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head    = e0;
    assign tail_pc = e1.pc;

endmodule

// File: rtl/imem_fetch_arb.sv
// Instruction memory port arbiter: sequential fetch into a 2-entry prefetch
// queue, byte-wide loader access with bounded burst length, redirects and
// sticky fetch faults. Redirect > loader > fetch.
module imem_fetch_arb import imem_pkg::*; #(
    parameter int          MEM_BYTES    = MEM_BYTES_DEF,
    parameter logic [31:0] RESET_PC     = 32'h0,
    parameter int          MAX_LD_BURST = 4
) (
    input logic              clk,
    input logic              reset_n,
    imem_fetch_arb_if.slave  bus
);

    localparam int          BW        = $clog2(MAX_LD_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_LD_BURST);
    localparam logic [31:0] PC_MAX    = 32'(MEM_BYTES - 4);

    logic [1:0]    state;
    logic [31:0]   fetch_pc;
    logic          fault_q;
    logic [31:0]   fault_pc_q;
    logic [BW-1:0] burst_cnt;

    logic [1:0]    q_count;
    qent_t         q_head;
    logic [31:0]   q_tail_pc;
    qent_t         q_din;

    logic q_valid, q_full, force_fetch, grant, fetch_go, fetch_ok, fetch_bad;
    logic ld_wr, pop, flush;
    logic [31:0] resync_pc;

    assign q_valid = (q_count != 2'd0);
    assign q_full  = (q_count == 2'd2);

    // After a full burst the loader yields one cycle, but only if a fetch could use it.
    assign force_fetch = (burst_cnt >= BURST_MAX) && !q_full && (state != S_FAULT);
    // Gated by reset_n so the combinational grant drops with an asynchronous reset.
    assign grant     = reset_n && bus.ld_req && !bus.redirect && !force_fetch;
    assign fetch_go  = !bus.redirect && !grant && (state != S_FAULT) && !q_full;
    assign fetch_ok  = fetch_go && pc_legal(fetch_pc, PC_MAX);
    assign fetch_bad = fetch_go && !pc_legal(fetch_pc, PC_MAX);
    assign ld_wr     = grant && bus.ld_we;
    assign pop       = q_valid && bus.instr_ready;
    assign flush     = bus.redirect || ld_wr;
    assign q_din     = {fetch_pc, bus.mem_rdata};

    // Oldest word decode has not yet consumed; a head popped this cycle is already gone.
    assign resync_pc = pop ? ((q_count == 2'd2) ? q_tail_pc : fetch_pc)
                           : (q_valid ? q_head.pc : fetch_pc);

    fetch_q2 u_q (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fetch_ok),
        .pop     (pop),
        .flush   (flush),
        .din     (q_din),
        .count   (q_count),
        .head    (q_head),
        .tail_pc (q_tail_pc)
    );

    // Port ownership and output presentation.
    assign bus.mem_addr    = grant ? bus.ld_addr : fetch_pc;
    assign bus.mem_wdata   = bus.ld_wdata;
    assign bus.mem_we      = ld_wr;
    assign bus.ld_gnt      = grant;
    assign bus.ld_rdata    = bus.mem_rdata;
    assign bus.instr_valid = q_valid;
    assign bus.instr       = q_valid ? q_head.instr : 32'h0;
    assign bus.instr_pc    = q_valid ? q_head.pc : 32'h0;
    assign bus.fault       = fault_q;
    assign bus.fault_pc    = fault_pc_q;

    // Counts consecutive loader grants, saturating; any non-granted cycle restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            burst_cnt <= '0;
        end else if (grant) begin
            if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 1'b1;
        end else begin
            burst_cnt <= '0;
        end
    end

    // FSM, fetch PC sequencing and fault capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_FETCH;
            fetch_pc   <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= 32'h0;
        end else if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc;
            if (!(state == S_FAULT && !pc_legal(bus.redirect_pc, PC_MAX))) begin
                state   <= S_FETCH;
                fault_q <= 1'b0;
            end
        end else begin
            if (ld_wr) begin
                fetch_pc <= resync_pc;
            end else if (fetch_ok) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (fetch_bad) begin
                fault_q    <= 1'b1;
                fault_pc_q <= fetch_pc;
                state      <= S_FAULT;
            end else if (state != S_FAULT) begin
                state <= grant ? S_LOAD : S_FETCH;
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch_arb.sv
// Randomized and directed bench for imem_fetch_arb with a queue-level
// reference model of the fetch/loader rules.
module tb_imem_fetch_arb;

    localparam int MEMB = 128;
    localparam int MAXB = 4;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    imem_fetch_arb_if bus();

    imem_fetch_arb #(.MEM_BYTES(MEMB), .RESET_PC(32'h0), .MAX_LD_BURST(MAXB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Environment memory: written only by the DUT's strobes.
    logic [7:0]  env_mem [MEMB];
    logic [31:0] ea1, ea2, ea3;
    assign ea1 = bus.mem_addr + 32'd1;
    assign ea2 = bus.mem_addr + 32'd2;
    assign ea3 = bus.mem_addr + 32'd3;
    assign bus.mem_rdata = {(ea3 < 32'd128) ? env_mem[ea3[6:0]] : 8'h00,
                            (ea2 < 32'd128) ? env_mem[ea2[6:0]] : 8'h00,
                            (ea1 < 32'd128) ? env_mem[ea1[6:0]] : 8'h00,
                            (bus.mem_addr < 32'd128) ? env_mem[bus.mem_addr[6:0]] : 8'h00};

    // Reference model state.
    logic [7:0]  mmem [MEMB];
    logic [63:0] mq [$];
    logic [31:0] m_fpc;
    logic        m_flt;
    logic [31:0] m_fltpc;
    int          m_bcnt;
    logic        s_gnt;

    function automatic logic [7:0] mb(input logic [31:0] a);
        return (a < 32'd128) ? mmem[a[6:0]] : 8'h00;
    endfunction

    function automatic logic [31:0] mword(input logic [31:0] a);
        return {mb(a + 32'd3), mb(a + 32'd2), mb(a + 32'd1), mb(a)};
    endfunction

    function automatic logic legal(input logic [31:0] pc);
        return (pc[1:0] == 2'b00) && (pc <= 32'(MEMB - 4));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fpc   = 32'h0;
        m_flt   = 1'b0;
        m_fltpc = 32'h0;
        m_bcnt  = 0;
    endtask

    task automatic set_idle();
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.ld_req      = 1'b0;
        bus.ld_we       = 1'b0;
        bus.ld_addr     = 32'h0;
        bus.ld_wdata    = 8'h00;
    endtask

    // One clock: compare against the model, then advance env memory and model.
    task automatic tick();
        logic        r_redir, r_lreq, r_lwe, r_rdy;
        logic [31:0] r_rpc, r_laddr;
        logic [7:0]  r_lwd;
        logic        e_force, e_gnt, e_fetch, e_pop;
        logic        d_we;
        logic [31:0] d_addr;
        logic [7:0]  d_wd;
        #1;
        r_redir = bus.redirect;  r_rpc = bus.redirect_pc;
        r_lreq  = bus.ld_req;    r_lwe = bus.ld_we;
        r_laddr = bus.ld_addr;   r_lwd = bus.ld_wdata;
        r_rdy   = bus.instr_ready;
        e_force = (m_bcnt >= MAXB) && (mq.size() < 2) && !m_flt;
        e_gnt   = r_lreq && !r_redir && !e_force;
        e_fetch = !r_redir && !e_gnt && !m_flt && (mq.size() < 2);
        e_pop   = (mq.size() > 0) && r_rdy;

        chk("instr_valid", 32'(bus.instr_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("instr", bus.instr, mq[0][31:0]);
            chk("instr_pc", bus.instr_pc, mq[0][63:32]);
        end
        chk("fault", 32'(bus.fault), 32'(m_flt));
        chk("fault_pc", bus.fault_pc, m_fltpc);
        chk("ld_gnt", 32'(bus.ld_gnt), 32'(e_gnt));
        chk("mem_we", 32'(bus.mem_we), 32'(e_gnt && r_lwe));
        if (e_gnt) begin
            chk("mem_addr_ld", bus.mem_addr, r_laddr);
            if (r_lwe) chk("mem_wdata", 32'(bus.mem_wdata), 32'(r_lwd));
            else       chk("ld_rdata", bus.ld_rdata, mword(r_laddr));
        end
        if (e_fetch) chk("mem_addr_fetch", bus.mem_addr, m_fpc);
        s_gnt  = bus.ld_gnt;
        d_we   = bus.mem_we;
        d_addr = bus.mem_addr;
        d_wd   = bus.mem_wdata;

        @(posedge clk);
        if (d_we && d_addr < 32'd128) env_mem[d_addr[6:0]] = d_wd;

        if (r_redir) begin
            mq.delete();
            if (m_flt && legal(r_rpc)) m_flt = 1'b0;
            m_fpc = r_rpc;
        end else if (e_gnt && r_lwe) begin
            if (e_pop) void'(mq.pop_front());
            if (mq.size() > 0) m_fpc = mq[0][63:32];
            mq.delete();
            if (r_laddr < 32'd128) mmem[r_laddr[6:0]] = r_lwd;
        end else begin
            if (e_pop) void'(mq.pop_front());
            if (e_fetch) begin
                if (legal(m_fpc)) begin
                    mq.push_back({m_fpc, mword(m_fpc)});
                    m_fpc = m_fpc + 32'd4;
                end else begin
                    m_flt   = 1'b1;
                    m_fltpc = m_fpc;
                end
            end
        end
        m_bcnt = e_gnt ? ((m_bcnt < MAXB) ? m_bcnt + 1 : MAXB) : 0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        set_idle();
        @(negedge clk);
        @(negedge clk);
        model_reset();
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_instr_pc", bus.instr_pc, 32'h0);
        chk("rst_fault", 32'(bus.fault), 32'h0);
        chk("rst_fault_pc", bus.fault_pc, 32'h0);
        chk("rst_ld_gnt", 32'(bus.ld_gnt), 32'h0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [9:0] gpat;
        logic [7:0] b;
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        bus.instr_ready = 1'b0;
        set_idle();
        for (int i = 0; i < MEMB; i++) begin
            b = 8'($urandom);
            env_mem[i] = b;
            mmem[i]    = b;
        end
        env_mem[0] = 8'hd3; env_mem[1] = 8'h07; env_mem[2] = 8'h56; env_mem[3] = 8'h00;
        env_mem[4] = 8'h53; env_mem[5] = 8'h85; env_mem[6] = 8'h84; env_mem[7] = 8'h08;
        for (int i = 0; i < 8; i++) mmem[i] = env_mem[i];

        // First fetches after reset.
        bus.instr_ready = 1'b1;
        do_reset();
        tick();
        chk("first_valid", 32'(bus.instr_valid), 32'h1);
        chk("first_instr", bus.instr, 32'h005607d3);
        chk("first_pc", bus.instr_pc, 32'h0);
        tick();
        chk("second_instr", bus.instr, 32'h08848553);
        chk("second_pc", bus.instr_pc, 32'h4);

        // Backpressure: queue fills with pc 0,4 and the fetch PC holds at 8.
        bus.instr_ready = 1'b0;
        do_reset();
        repeat (5) tick();
        chk("stall_head_pc", bus.instr_pc, 32'h0);
        #1 chk("stall_mem_addr", bus.mem_addr, 32'h8);
        @(negedge clk);
        bus.instr_ready = 1'b1;
        tick();
        chk("drain_pc4", bus.instr_pc, 32'h4);
        tick();
        chk("drain_pc8", bus.instr_pc, 32'h8);

        // Redirect with a full queue.
        bus.instr_ready = 1'b0;
        repeat (2) tick();
        bus.redirect = 1'b1; bus.redirect_pc = 32'h18;
        tick();
        set_idle();
        chk("redir_flush", 32'(bus.instr_valid), 32'h0);
        bus.instr_ready = 1'b1;
        tick();
        chk("redir_valid", 32'(bus.instr_valid), 32'h1);
        chk("redir_pc", bus.instr_pc, 32'h18);

        // Loader burst of reads with fetch pending.
        gpat = '0;
        bus.ld_req = 1'b1; bus.ld_we = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.ld_addr = 32'($urandom_range(0, 124));
            tick();
            gpat[9 - i] = s_gnt;
        end
        set_idle();
        chk("burst_pattern", 32'(gpat), 32'(10'b1111011110));

        // Loader write to a queued word forces a refetch.
        bus.instr_ready = 1'b0;
        bus.redirect = 1'b1; bus.redirect_pc = 32'h0;
        tick();
        set_idle();
        tick();
        chk("wr_head_pc", bus.instr_pc, 32'h0);
        bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 32'h0; bus.ld_wdata = 8'h13;
        tick();
        set_idle();
        chk("wr_flush", 32'(bus.instr_valid), 32'h0);
        tick();
        chk("wr_refetch_pc", bus.instr_pc, 32'h0);
        chk("wr_refetch", bus.instr, 32'h00560713);

        // Misaligned redirect faults, a legal one recovers.
        bus.instr_ready = 1'b1;
        bus.redirect = 1'b1; bus.redirect_pc = 32'h2;
        tick();
        set_idle();
        tick();
        chk("fault_set", 32'(bus.fault), 32'h1);
        chk("fault_pc2", bus.fault_pc, 32'h2);
        tick();
        chk("fault_nopush", 32'(bus.instr_valid), 32'h0);
        bus.redirect = 1'b1; bus.redirect_pc = 32'h8;
        tick();
        set_idle();
        chk("fault_clear", 32'(bus.fault), 32'h0);
        tick();
        chk("recover_pc8", bus.instr_pc, 32'h8);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            bus.instr_ready = ($urandom_range(0, 9) < 7);
            bus.redirect    = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) bus.redirect_pc = $urandom;
            else                           bus.redirect_pc = {25'h0, 5'($urandom_range(0, 31)), 2'b00};
            if ($urandom_range(0, 5) == 0) bus.ld_req = ~bus.ld_req;
            bus.ld_we    = ($urandom_range(0, 3) == 0);
            bus.ld_addr  = 32'($urandom_range(0, 127));
            bus.ld_wdata = 8'($urandom);
            tick();
        end
        set_idle();

        // Asynchronous reset in the middle of a loader burst.
        bus.instr_ready = 1'b0;
        bus.redirect = 1'b1; bus.redirect_pc = 32'h0;
        tick();
        set_idle();
        tick();
        bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 32'h40; bus.ld_wdata = 8'h5a;
        tick();
        bus.ld_we = 1'b0;
        tick();
        #3 reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.instr_valid), 32'h0);
        chk("arst_instr", bus.instr, 32'h0);
        chk("arst_pc", bus.instr_pc, 32'h0);
        chk("arst_gnt", 32'(bus.ld_gnt), 32'h0);
        chk("arst_we", 32'(bus.mem_we), 32'h0);
        chk("arst_fault", 32'(bus.fault), 32'h0);
        chk("arst_fault_pc", bus.fault_pc, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
